// File: rtl/r_type_alu.sv
`default_nettype none
// ============================================================================
// Module      : r_type_alu
// Description : Registered execute unit for RV32I register-register integer
//               instructions (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR,
//               AND). Decodes opcode/funct3/funct7, computes the result
//               combinationally and registers it with a fixed one-cycle
//               latency. Unsupported encodings produce rd=0 with the illegal
//               flag raised.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     operands and instruction fields valid this cycle
//   opcode     in   7     instruction opcode (R-type = 7'b0110011)
//   funct3     in   3     operation select
//   funct7     in   7     operation modifier (7'h00 or 7'h20)
//   rs1        in   XLEN  first source operand
//   rs2        in   XLEN  second source operand
//   rd         out  XLEN  registered result
//   out_valid  out  1     registered copy of in_valid
//   illegal    out  1     registered unsupported-encoding flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module r_type_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] rd,
    output logic            out_valid,
    output logic            illegal
);

    // Shift-amount width follows the operand width; only the low SHW bits
    // of rs2 select the shift distance.
    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] c_OPCODE_OP = 7'b0110011;
    localparam logic [6:0] c_F7_BASE   = 7'h00;
    localparam logic [6:0] c_F7_ALT    = 7'h20;

    localparam logic [2:0] c_F3_ADD_SUB = 3'd0;
    localparam logic [2:0] c_F3_SLL     = 3'd1;
    localparam logic [2:0] c_F3_SLT     = 3'd2;
    localparam logic [2:0] c_F3_SLTU    = 3'd3;
    localparam logic [2:0] c_F3_XOR     = 3'd4;
    localparam logic [2:0] c_F3_SRL_SRA = 3'd5;
    localparam logic [2:0] c_F3_OR      = 3'd6;
    localparam logic [2:0] c_F3_AND     = 3'd7;

    // Internal operation code produced by the decoder.
    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_SLL     = 4'd2,
        OP_SLT     = 4'd3,
        OP_SLTU    = 4'd4,
        OP_XOR     = 4'd5,
        OP_SRL     = 4'd6,
        OP_SRA     = 4'd7,
        OP_OR      = 4'd8,
        OP_AND     = 4'd9,
        OP_ILLEGAL = 4'd15
    } alu_op_t;

    alu_op_t         w_op;
    logic            w_is_op;
    logic            w_f7_base;
    logic            w_f7_alt;
    logic [SHW-1:0]  w_shamt;
    logic            w_lt_signed;
    logic            w_lt_unsigned;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;

    logic [XLEN-1:0] r_rd;
    logic            r_out_valid;
    logic            r_illegal;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    assign w_is_op   = (opcode == c_OPCODE_OP);
    assign w_f7_base = (funct7 == c_F7_BASE);
    assign w_f7_alt  = (funct7 == c_F7_ALT);

    // Only funct3=0 and funct3=5 accept the alternate funct7; every other
    // funct7 value (including the M-extension 7'h01) falls through to
    // OP_ILLEGAL.
    always_comb begin
        w_op = OP_ILLEGAL;
        if (w_is_op) begin
            unique case (funct3)
                c_F3_ADD_SUB: begin
                    if (w_f7_base)     w_op = OP_ADD;
                    else if (w_f7_alt) w_op = OP_SUB;
                end
                c_F3_SLL:  if (w_f7_base) w_op = OP_SLL;
                c_F3_SLT:  if (w_f7_base) w_op = OP_SLT;
                c_F3_SLTU: if (w_f7_base) w_op = OP_SLTU;
                c_F3_XOR:  if (w_f7_base) w_op = OP_XOR;
                c_F3_SRL_SRA: begin
                    if (w_f7_base)     w_op = OP_SRL;
                    else if (w_f7_alt) w_op = OP_SRA;
                end
                c_F3_OR:   if (w_f7_base) w_op = OP_OR;
                c_F3_AND:  if (w_f7_base) w_op = OP_AND;
                default:   w_op = OP_ILLEGAL;
            endcase
        end
    end

    assign w_illegal = (w_op == OP_ILLEGAL);

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    assign w_shamt       = rs2[SHW-1:0];
    assign w_sum         = rs1 + rs2;
    assign w_diff        = rs1 - rs2;
    assign w_lt_signed   = ($signed(rs1) < $signed(rs2));
    assign w_lt_unsigned = (rs1 < rs2);

    always_comb begin
        w_result = '0;
        unique case (w_op)
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_SLL:  w_result = rs1 << w_shamt;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            OP_XOR:  w_result = rs1 ^ rs2;
            OP_SRL:  w_result = rs1 >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(rs1) >>> w_shamt);
            OP_OR:   w_result = rs1 | rs2;
            OP_AND:  w_result = rs1 & rs2;
            // Unsupported encodings always report a zero result.
            default: w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // rd and illegal only load on accepted operations so that a bubble
    // leaves the last result visible to downstream logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_rd      <= w_result;
                r_illegal <= w_illegal;
            end
        end
    end

    assign rd        = r_rd;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_r_type_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_r_type_alu
// Description : Scoreboard bench for r_type_alu. The driver applies one
//               directed vector per cycle on the falling edge and pushes the
//               hand-computed expected output for the following rising edge;
//               a monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r_type_alu;

    localparam int XLEN = 32;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rd;
    logic            out_valid;
    logic            illegal;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] last_rd;
    logic        last_ill;

    r_type_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, what, act, exp_v);
        end
    endtask

    // Driver: one vector per falling edge. Expected rd/illegal follow the
    // hold-on-bubble and reset rules of the block.
    task automatic drive(input string tag, input logic r, input logic v,
                         input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd,
                         input logic exp_ill);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        rs1      = a;
        rs2      = b;
        if (r) begin
            last_rd  = 32'h0;
            last_ill = 1'b0;
        end else if (v) begin
            last_rd  = exp_rd;
            last_ill = exp_ill;
        end
        e.tag   = tag;
        e.valid = v & ~r;
        e.rd    = last_rd;
        e.ill   = last_ill;
        sb_q.push_back(e);
    endtask

    task automatic op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_rd);
        drive(tag, 1'b0, 1'b1, c_OP_R, f3, f7, a, b, exp_rd, 1'b0);
    endtask

    task automatic bad(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7);
        drive(tag, 1'b0, 1'b1, opc, f3, f7, 32'h1234_5678, 32'h0000_0003, 32'h0, 1'b1);
    endtask

    task automatic bubble(input string tag);
        drive(tag, 1'b0, 1'b0, c_OP_R, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b0);
    endtask

    // Monitor: compares the DUT outputs against the scoreboard after every
    // rising edge for which an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.tag, "out_valid", {31'b0, out_valid}, {31'b0, e.valid});
                check(e.tag, "rd", rd, e.rd);
                check(e.tag, "illegal", {31'b0, illegal}, {31'b0, e.ill});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_rd  = 32'h0;
        last_ill = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = c_OP_R;
        funct3   = 3'd0;
        funct7   = 7'h00;
        rs1      = '0;
        rs2      = '0;

        // Reset overrides in_valid.
        drive("reset0", 1'b1, 1'b1, c_OP_R, 3'd0, 7'h00, 32'd4, 32'd6, 32'h0, 1'b0);
        drive("reset1", 1'b1, 1'b1, c_OP_R, 3'd0, 7'h00, 32'd4, 32'd6, 32'h0, 1'b0);

        op("add_4_6",      3'd0, 7'h00, 32'd4,        32'd6,        32'd10);
        op("add_neg",      3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
        op("add_wrap",     3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000);
        op("sub_4_6",      3'd0, 7'h20, 32'd4,        32'd6,        32'hFFFF_FFFE);
        op("sub_neg",      3'd0, 7'h20, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd2);
        op("slt_m1_1",     3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1,        32'd1);
        op("sltu_m1_1",    3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1,        32'd0);
        op("slt_eq",       3'd2, 7'h00, 32'd5,        32'd5,        32'd0);
        op("sltu_0_max",   3'd3, 7'h00, 32'd0,        32'hFFFF_FFFF, 32'd1);
        op("sll_31",       3'd1, 7'h00, 32'd1,        32'd31,       32'h8000_0000);
        op("sll_33",       3'd1, 7'h00, 32'd1,        32'd33,       32'd2);
        op("srl_31",       3'd5, 7'h00, 32'h8000_0000, 32'd31,       32'd1);
        op("sra_4",        3'd5, 7'h20, 32'h8000_0000, 32'd4,        32'hF800_0000);
        op("sra_0",        3'd5, 7'h20, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321);
        op("srl_neg_4",    3'd5, 7'h00, 32'h8000_0000, 32'd4,        32'h0800_0000);
        op("xor",          3'd4, 7'h00, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        op("or",           3'd6, 7'h00, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        op("and",          3'd7, 7'h00, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        bubble("bubble_hold_and");
        bad("ill_f3_1_f7_20", c_OP_R,   3'd1, 7'h20);
        bubble("bubble_hold_ill");
        bad("ill_opimm",      c_OP_IMM, 3'd0, 7'h00);
        bad("ill_mul",        c_OP_R,   3'd0, 7'h01);
        op("b2b_add",      3'd0, 7'h00, 32'd1,        32'd2,        32'd3);
        op("b2b_sub",      3'd0, 7'h20, 32'd10,       32'd3,        32'd7);
        op("b2b_and",      3'd7, 7'h00, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
        // Reset mid-stream discards the accepted operation.
        drive("reset_mid", 1'b1, 1'b1, c_OP_R, 3'd0, 7'h00, 32'd7, 32'd8, 32'h0, 1'b0);
        op("post_reset",   3'd0, 7'h00, 32'd4,        32'd6,        32'd10);
        bubble("final_idle");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r_type_alu.md
Name: r_type_alu

Overview:
- Registered execute unit for RV32I register-register (R-type) integer instructions: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Takes the decoded opcode, funct3 and funct7 fields plus two source operand values. Produces the destination value one clock later.
- Sits in the execute stage between register-file read and writeback. Flags encodings it does not support.

Parameters:
- XLEN, 32, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands and fields valid this cycle.
- opcode  in  7  instruction opcode; R-type = 7'b0110011.
- funct3  in  3  operation select.
- funct7  in  7  operation modifier (7'h00 or 7'h20).
- rs1  in  XLEN  first source operand value.
- rs2  in  XLEN  second source operand value.
- rd  out  XLEN  registered result value.
- out_valid  out  1  rd valid; registered copy of in_valid.
- illegal  out  1  registered flag: unsupported encoding accepted.

Behaviour:
- Clocking and reset:
  - One clock domain. All outputs update on the rising edge of clk.
  - When rst=1 at an edge: rd<=0, out_valid<=0, illegal<=0. Reset overrides in_valid.
  - Reset asserted mid-operation discards the in-flight result.
- Latency and handshake:
  - Fixed 1-cycle latency, fully pipelined; one new operation accepted every cycle.
  - No backpressure.
  - out_valid(t+1) = in_valid(t).
  - When in_valid=0, rd and illegal hold their previous values.
- Decode (when opcode=0110011; operands two's-complement, result wraps mod 2^XLEN):
  - f3=0, f7=00: ADD, rd = rs1+rs2, carry discarded.
  - f3=0, f7=20: SUB, rd = rs1-rs2, borrow discarded.
  - f3=1, f7=00: SLL, rd = rs1 << rs2[SHW-1:0].
  - f3=2, f7=00: SLT, rd = 1 if signed rs1 < signed rs2, else 0 (zero-extended).
  - f3=3, f7=00: SLTU, same as SLT with unsigned compare.
  - f3=4, f7=00: XOR.
  - f3=5, f7=00: SRL, logical right shift by rs2[SHW-1:0].
  - f3=5, f7=20: SRA, arithmetic right shift by rs2[SHW-1:0], sign-filled.
  - f3=6, f7=00: OR.
  - f3=7, f7=00: AND.
- Shift amount: upper bits of rs2 above SHW are ignored. A shift by 0 returns rs1 unchanged.
- Illegal encodings:
  - Any other funct7/funct3 combination (including M-extension funct7=01) or opcode != 0110011.
  - With in_valid=1, the result is rd<=0, illegal<=1, out_valid<=1.
  - illegal=0 for every legal operation.
- Overflow: no overflow flag. ADD/SUB wrap silently (e.g. 0x7FFFFFFF+1 = 0x80000000).

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> rd=0, out_valid=0, illegal=0. Release rst; ADD 4+6 issued -> next cycle rd=10, out_valid=1.
- ADD/SUB, f3=0:
  - f7=00: 4,6 -> 10; -2,-4 -> 0xFFFFFFFA (-6); 0x7FFFFFFF,1 -> 0x80000000.
  - f7=20: 4,6 -> 0xFFFFFFFE (-2); -2,-4 -> 2.
- Compares:
  - SLT -1,1 -> 1; SLTU -1,1 -> 0.
  - SLT 5,5 -> 0.
  - SLTU 0,0xFFFFFFFF -> 1.
- Shifts:
  - SLL 1, rs2=31 -> 0x80000000.
  - SLL 1, rs2=33 -> 2 (only low 5 bits used).
  - SRL 0x80000000, 31 -> 1.
  - SRA 0x80000000, 4 -> 0xF8000000.
  - SRA x, 0 -> x.
- Logic with rs1=0xF0F0_00FF, rs2=0x0FF0_0F0F:
  - XOR -> 0xFF00_0FF0.
  - OR -> 0xFFF0_0FFF.
  - AND -> 0x00F0_000F.
- Illegal and pipelining:
  - f3=1, f7=20 -> rd=0, illegal=1.
  - opcode=0010011 -> illegal=1.
  - funct7=01 (MUL) -> illegal=1.
  - Back-to-back ADD/SUB/AND on consecutive cycles -> results appear on consecutive cycles with out_valid held at 1.
  - An in_valid=0 bubble -> out_valid=0 and rd held for that cycle.
